regfile_param: RTL

- Parametrised successor to the 8x8 register file in the single-cycle processor datapath.
- Storage is 2^ADDR_WIDTH entries of DATA_WIDTH bits, with one write port and two registered read ports.
- Adds write enable, write-first bypass, an optional hardwired-zero register 0, and a sequenced clear engine with a busy flag.
- Feeds ALU operand muxes; the write port is driven by the ALU result path.

---
 rtl/regfile_param.sv | 137 +++++++++++++
 1 files changed

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised register file with bypass, zero register and clear engine
module regfile_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               wr_en,
    input  logic [ADDR_WIDTH-1:0]              in_addr,
    input  logic [DATA_WIDTH-1:0]              in_data,
    input  logic [ADDR_WIDTH-1:0]              out1_addr,
    output logic [DATA_WIDTH-1:0]              out1_data,
    input  logic [ADDR_WIDTH-1:0]              out2_addr,
    output logic [DATA_WIDTH-1:0]              out2_data,
    input  logic                               clear_req,
    output logic                               busy,
    output logic                               wr_drop,
    output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] debug_flat
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEARING
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    clearing;
    logic                    wr_accept;
    logic [DATA_WIDTH-1:0]   rd1_next;
    logic [DATA_WIDTH-1:0]   rd2_next;

    // Value an entry will hold after this edge, as seen by a read port
    function automatic logic [DATA_WIDTH-1:0] read_next(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  clr,
        input logic [ADDR_WIDTH-1:0] clr_ptr,
        input logic                  wa,
        input logic [ADDR_WIDTH-1:0] waddr,
        input logic [DATA_WIDTH-1:0] wdata
    );
        logic [DATA_WIDTH-1:0] v;
        v = stored;
        if ((ZERO_REG != 0) && (addr == '0)) begin
            v = '0;
        end else if (clr && (addr == clr_ptr)) begin
            v = '0;
        end else if (wa && (addr == waddr)) begin
            v = wdata;
        end
        return v;
    endfunction

    // Write qualification and next-state read values for both ports
    always_comb begin
        clearing  = (state == CLEARING);
        wr_accept = wr_en && (state == IDLE) && !((ZERO_REG != 0) && (in_addr == '0));
        rd1_next  = read_next(out1_addr, mem[out1_addr], clearing, ptr, wr_accept, in_addr, in_data);
        rd2_next  = read_next(out2_addr, mem[out2_addr], clearing, ptr, wr_accept, in_addr, in_data);
    end

    // Storage: normal writes in IDLE, one entry zeroed per edge while clearing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_accept) begin
                mem[in_addr] <= in_data;
            end
            if (clearing) begin
                mem[ptr] <= '0;
            end
        end
    end

    // Clear sequencer; ptr stops at the last entry instead of wrapping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ptr     <= '0;
            busy    <= 1'b0;
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= wr_en && (state == CLEARING);
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state <= CLEARING;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEARING: begin
                    if (ptr == LAST_PTR) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Registered read ports
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out1_data <= '0;
            out2_data <= '0;
        end else begin
            out1_data <= rd1_next;
            out2_data <= rd2_next;
        end
    end

    // Flattened view of the array for observation
    always_comb begin
        debug_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            debug_flat[i*DATA_WIDTH +: DATA_WIDTH] = mem[i];
        end
    end

endmodule
